seq_multiplier: RTL and testbench

Parametrised multi-cycle shift-add multiplier; the successor to the team's 4-bit combinational multiplier. It takes WIDTH-bit operands through a valid/ready handshake and returns a registered 2*WIDTH-bit product after a fixed latency. A per-transaction mode bit selects signed or unsigned multiplication. It sits on the datapath wherever a full-width array multiplier is too costly in area.

---
 rtl/seq_mul_pkg.sv | 7 +
 rtl/seq_mul_abs.sv | 10 +
 rtl/seq_multiplier.sv | 84 ++++++++
 tb/tb_seq_multiplier.sv | 106 ++++++++++
 4 files changed

// File: rtl/seq_mul_pkg.sv
// seq_mul_pkg: shared state encoding and sizing helper for the shift-add multiplier
package seq_mul_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;
  function automatic int cnt_w(input int w);
    return $clog2(w + 1);
  endfunction
endpackage

// File: rtl/seq_mul_abs.sv
// seq_mul_abs: conditional two's-complement negate
module seq_mul_abs #(
  parameter int W = 8
) (
  input  logic         neg_i,
  input  logic [W-1:0] x_i,
  output logic [W-1:0] y_o
);
  assign y_o = neg_i ? (~x_i + W'(1)) : x_i;
endmodule

// File: rtl/seq_multiplier.sv
// seq_multiplier: multi-cycle shift-add multiplier, signed or unsigned per transaction
module seq_multiplier
  import seq_mul_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit SIGNED_EN = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic                 signed_mode,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   product,
  output logic                 busy
);
  localparam int CW = cnt_w(WIDTH);
  localparam int PW = 2 * WIDTH;
  state_e          state_q, state_d;
  logic [PW-1:0]   mcand_q, mcand_d, acc_q, acc_d, product_q, product_d, acc_sum, acc_fix;
  logic [WIDTH-1:0] mplier_q, mplier_d, mag_a, mag_b;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            neg_q, neg_d, sop;
  assign sop = signed_mode & SIGNED_EN;
  seq_mul_abs #(.W(WIDTH)) u_abs_a (.neg_i(sop & a[WIDTH-1]), .x_i(a), .y_o(mag_a));
  seq_mul_abs #(.W(WIDTH)) u_abs_b (.neg_i(sop & b[WIDTH-1]), .x_i(b), .y_o(mag_b));
  // The last partial product is folded in combinationally so the result lands on edge WIDTH.
  assign acc_sum = acc_q + (mplier_q[0] ? mcand_q : '0);
  seq_mul_abs #(.W(PW)) u_abs_p (.neg_i(neg_q), .x_i(acc_sum), .y_o(acc_fix));
  always_comb begin
    state_d   = state_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    neg_d     = neg_q;
    product_d = product_q;
    if (state_q == IDLE && in_valid) begin
      state_d  = RUN;
      mcand_d  = {{WIDTH{1'b0}}, mag_a};
      mplier_d = mag_b;
      acc_d    = '0;
      cnt_d    = '0;
      neg_d    = sop & (a[WIDTH-1] ^ b[WIDTH-1]);
    end else if (state_q == RUN) begin
      acc_d    = acc_sum;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + CW'(1);
      if (cnt_q == CW'(WIDTH - 1)) begin
        state_d   = DONE;
        product_d = acc_fix;
      end
    end else if (state_q == DONE && out_ready) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      mcand_q   <= '0;
      mplier_q  <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      neg_q     <= 1'b0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      neg_q     <= neg_d;
      product_q <= product_d;
    end
  end
  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign product   = product_q;
endmodule

// File: tb/tb_seq_multiplier.sv
// tb_seq_multiplier: directed checks of the shift-add multiplier, signed and unsigned builds
module tb_seq_multiplier;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0, out_ready = 1'b0, signed_mode = 1'b0;
  logic [7:0]  a = '0, b = '0;
  logic        in_ready, out_valid, busy, in_ready_u, out_valid_u, busy_u;
  logic [15:0] product, product_u;
  int          errors = 0, checks = 0;
  always #5 clk = ~clk;
  seq_multiplier #(.WIDTH(8), .SIGNED_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .signed_mode(signed_mode), .out_valid(out_valid), .out_ready(out_ready),
    .product(product), .busy(busy));
  // Unsigned-only build shares all stimulus, so it runs in lockstep with dut.
  seq_multiplier #(.WIDTH(8), .SIGNED_EN(1'b0)) dut_u (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_u), .a(a), .b(b),
    .signed_mode(signed_mode), .out_valid(out_valid_u), .out_ready(out_ready),
    .product(product_u), .busy(busy_u));
  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic start_op(input logic [7:0] av, input logic [7:0] bv, input logic sm,
                          input logic [15:0] exp, input logic [15:0] exp_u, input string tag);
    @(negedge clk);
    a = av; b = bv; signed_mode = sm; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk({tag, "_busy"}, {15'd0, busy}, 16'd1);
    chk({tag, "_in_ready_run"}, {15'd0, in_ready}, 16'd0);
    repeat (7) @(posedge clk);
    #1;
    chk({tag, "_valid_edge7"}, {15'd0, out_valid}, 16'd0);
    @(posedge clk); #1;
    chk({tag, "_valid_edge8"}, {15'd0, out_valid}, 16'd1);
    chk({tag, "_product"}, product, exp);
    chk({tag, "_product_u"}, product_u, exp_u);
  endtask
  task automatic release_op(input string tag);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk({tag, "_valid_drop"}, {15'd0, out_valid}, 16'd0);
    chk({tag, "_in_ready_idle"}, {15'd0, in_ready}, 16'd1);
    out_ready = 1'b0;
  endtask
  initial begin
    logic stable;
    logic [15:0] held;
    #1;
    chk("rst_in_ready", {15'd0, in_ready}, 16'd1);
    chk("rst_out_valid", {15'd0, out_valid}, 16'd0);
    chk("rst_busy", {15'd0, busy}, 16'd0);
    chk("rst_product", product, 16'd0);
    @(negedge clk);
    rst = 1'b0;
    start_op(8'd15, 8'd15, 1'b0, 16'h00E1, 16'h00E1, "u15x15");
    release_op("u15x15");
    start_op(8'hFD, 8'h05, 1'b1, 16'hFFF1, 16'h04F1, "s_m3x5");
    release_op("s_m3x5");
    start_op(8'hFD, 8'h05, 1'b0, 16'h04F1, 16'h04F1, "u253x5");
    release_op("u253x5");
    start_op(8'h80, 8'h80, 1'b1, 16'h4000, 16'h4000, "s_min_sq");
    release_op("s_min_sq");
    start_op(8'h7F, 8'h80, 1'b1, 16'hC080, 16'h3F80, "s_max_min");
    release_op("s_max_min");
    start_op(8'hFF, 8'hFF, 1'b0, 16'hFE01, 16'hFE01, "u_max_sq");
    release_op("u_max_sq");
    start_op(8'h00, 8'hFF, 1'b0, 16'h0000, 16'h0000, "u_zero");
    release_op("u_zero");
    start_op(8'd12, 8'd10, 1'b0, 16'd120, 16'd120, "bp");
    held = product;
    stable = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (product !== held || out_valid !== 1'b1 || in_ready !== 1'b0) stable = 1'b0;
    end
    chk("bp_stable", {15'd0, stable}, 16'd1);
    release_op("bp");
    chk("bp_product_kept", product, 16'd120);
    start_op(8'hF9, 8'h06, 1'b1, 16'hFFD6, 16'h05D6, "next_after_bp");
    release_op("next_after_bp");
    @(negedge clk);
    a = 8'd7; b = 8'd9; signed_mode = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("midrun_out_valid", {15'd0, out_valid}, 16'd0);
    chk("midrun_busy", {15'd0, busy}, 16'd0);
    chk("midrun_product", product, 16'd0);
    chk("midrun_in_ready", {15'd0, in_ready}, 16'd1);
    @(negedge clk);
    rst = 1'b0;
    start_op(8'd7, 8'd9, 1'b0, 16'd63, 16'd63, "after_rst");
    release_op("after_rst");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
